// File: rtl/decoder_pkg.sv
// Shared decode/execute types: data word, ALU op, operand selects.
// Imported by the ID/EX operand stage and its forward selector.
package decoder_pkg;

  typedef logic [31:0] word;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_ZERO = 2'b10
  } opsel_a_t;

  typedef enum logic [1:0] {
    OPB_RS2  = 2'b00,
    OPB_IMM  = 2'b01,
    OPB_FOUR = 2'b10
  } opsel_b_t;

  localparam word WORD_ZERO = 32'd0;
  localparam word WORD_FOUR = 32'd4;

  typedef struct packed {
    word     a;
    word     b;
    alu_op_t op;
    logic    sub_arith;
    logic    is_load;
  } id_ex_t;

  localparam id_ex_t ID_EX_RESET = '{
    a:         WORD_ZERO,
    b:         WORD_ZERO,
    op:        ALU_ADD,
    sub_arith: 1'b0,
    is_load:   1'b0
  };

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-operand forward selector: EX result, then WB data, then regfile.
// Ports: rs/used source, EX and WB producer tags+data, rf_data; ex_hit, data.
module fwd_mux
  import decoder_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  word               ex_res,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  word               wb_data,
  input  word               rf_data,
  output logic              ex_hit,
  output word               data
);

  logic nz;
  logic wb_hit;

  // x0 is hard-wired zero, so it never matches a producer
  assign nz     = (rs != '0);
  assign ex_hit = used & nz & ex_we & (ex_rd == rs);
  assign wb_hit = used & nz & wb_we & (wb_rd == rs);

  always_comb begin
    data = rf_data;
    if (ex_hit) begin
      data = ex_res;
    end else if (wb_hit) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage: operand select, EX/WB forwarding, load-use bubble, stall/flush.
// Ports: id_* decode offer + id_ready, ex_res/wb_* forward, ex_* ALU outputs.
module alu_operand_stage
  import decoder_pkg::*;
#(
  parameter int FORWARD = 1,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  word               id_rs1_data,
  input  word               id_rs2_data,
  input  word               id_imm,
  input  word               id_pc,
  input  opsel_a_t          id_a_sel,
  input  opsel_b_t          id_b_sel,
  input  alu_op_t           id_op,
  input  logic              id_sub_arith,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  word               ex_res,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  word               wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              ex_valid,
  output word               ex_a,
  output word               ex_b,
  output alu_op_t           ex_op,
  output logic              ex_sub_arith,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic              ex_is_load
);

  id_ex_t            ex_q;
  id_ex_t            ex_d;
  logic              ex_valid_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ex_we_q;

  logic use1;
  logic use2;
  logic hit1;
  logic hit2;
  logic ex_prod;
  logic ex_load;
  logic load_use;
  logic advance;
  logic accept;
  word  fwd1;
  word  fwd2;

  assign use1    = (id_a_sel == OPA_RS1);
  assign use2    = (id_b_sel == OPB_RS2);
  assign ex_prod = ex_valid_q & ex_we_q;
  assign ex_load = ex_valid_q & ex_q.is_load;

  fwd_mux #(
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .rs      (id_rs1),
    .used    (use1),
    .ex_we   (ex_prod),
    .ex_rd   (ex_rd_q),
    .ex_res  (ex_res),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .rf_data (id_rs1_data),
    .ex_hit  (hit1),
    .data    (fwd1)
  );

  fwd_mux #(
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .rs      (id_rs2),
    .used    (use2),
    .ex_we   (ex_prod),
    .ex_rd   (ex_rd_q),
    .ex_res  (ex_res),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .rf_data (id_rs2_data),
    .ex_hit  (hit2),
    .data    (fwd2)
  );

  // Without forwarding every EX producer stalls; with it only a load does.
  // A WB producer never stalls since its data is forwarded directly.
  assign load_use = id_valid & (hit1 | hit2)
                  & ((FORWARD == 0) | ex_load);

  assign advance  = ex_ready | ~ex_valid_q;
  assign id_ready = advance & ~load_use & ~flush;
  assign accept   = id_valid & id_ready;

  always_comb begin
    ex_d           = ID_EX_RESET;
    ex_d.op        = id_op;
    ex_d.sub_arith = id_sub_arith;
    ex_d.is_load   = id_is_load;
    unique case (id_a_sel)
      OPA_RS1: ex_d.a = fwd1;
      OPA_PC:  ex_d.a = id_pc;
      default: ex_d.a = WORD_ZERO;
    endcase
    unique case (id_b_sel)
      OPB_RS2: ex_d.b = fwd2;
      OPB_IMM: ex_d.b = id_imm;
      default: ex_d.b = WORD_FOUR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= ID_EX_RESET;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        ex_valid_q <= 1'b1;
        ex_q       <= ex_d;
        ex_rd_q    <= id_rd;
        ex_we_q    <= id_rd_we;
      end else begin
        ex_valid_q <= 1'b0;
        ex_we_q    <= 1'b0;
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_op        = ex_q.op;
  assign ex_sub_arith = ex_q.sub_arith;
  assign ex_rd        = ex_rd_q;
  assign ex_rd_we     = ex_valid_q & ex_we_q;
  assign ex_is_load   = ex_valid_q & ex_q.is_load;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: cycle table on a forwarding instance,
// plus hand sequences for the non-forwarding instance and mid-run reset.
module tb_alu_operand_stage;
  import decoder_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  word        id_rs1_data;
  word        id_rs2_data;
  word        id_imm;
  word        id_pc;
  opsel_a_t   id_a_sel;
  opsel_b_t   id_b_sel;
  alu_op_t    id_op;
  logic       id_sub_arith;
  logic [4:0] id_rd;
  logic       id_rd_we;
  logic       id_is_load;
  word        ex_res;
  logic [4:0] wb_rd;
  logic       wb_we;
  word        wb_data;
  logic       ex_ready;
  logic       flush;

  logic       f_idr, f_v, f_sub, f_we, f_ld;
  word        f_a, f_b;
  alu_op_t    f_op;
  logic [4:0] f_rd;

  logic       n_idr, n_v, n_sub, n_we, n_ld;
  word        n_a, n_b;
  alu_op_t    n_op;
  logic [4:0] n_rd;

  int n_cmp;
  int n_bad;

  alu_operand_stage #(.FORWARD(1), .REG_AW(5)) u_fw (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_ready(f_idr),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_op(id_op), .id_sub_arith(id_sub_arith),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .ex_res(ex_res), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(f_v), .ex_a(f_a), .ex_b(f_b), .ex_op(f_op),
    .ex_sub_arith(f_sub), .ex_rd(f_rd), .ex_rd_we(f_we),
    .ex_is_load(f_ld)
  );

  alu_operand_stage #(.FORWARD(0), .REG_AW(5)) u_nf (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_ready(n_idr),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_op(id_op), .id_sub_arith(id_sub_arith),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .ex_res(ex_res), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(n_v), .ex_a(n_a), .ex_b(n_b), .ex_op(n_op),
    .ex_sub_arith(n_sub), .ex_rd(n_rd), .ex_rd_we(n_we),
    .ex_is_load(n_ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    word        d1;
    word        d2;
    word        imm;
    word        pc;
    opsel_a_t   asel;
    opsel_b_t   bsel;
    alu_op_t    op;
    logic       sub;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    word        exr;
    logic [4:0] wrd;
    logic       wwe;
    word        wd;
    logic       rdy;
    logic       fl;
    logic       e_idr;
    logic       e_v;
    word        e_a;
    word        e_b;
    logic [4:0] e_rd;
    logic       e_we;
    alu_op_t    e_op;
    logic       e_sub;
    logic       e_ld;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid     = t.v;
    id_rs1       = t.rs1;
    id_rs2       = t.rs2;
    id_rs1_data  = t.d1;
    id_rs2_data  = t.d2;
    id_imm       = t.imm;
    id_pc        = t.pc;
    id_a_sel     = t.asel;
    id_b_sel     = t.bsel;
    id_op        = t.op;
    id_sub_arith = t.sub;
    id_rd        = t.rd;
    id_rd_we     = t.we;
    id_is_load   = t.ld;
    ex_res       = t.exr;
    wb_rd        = t.wrd;
    wb_we        = t.wwe;
    wb_data      = t.wd;
    ex_ready     = t.rdy;
    flush        = t.fl;
  endtask

  task automatic idle();
    vec_t t;
    t = '{0, 0, 0, 0, 0, 0, 0, OPA_RS1, OPB_RS2, ALU_ADD, 0, 0, 0, 0,
          0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, ALU_ADD, 0, 0};
    apply(t);
  endtask

  initial begin
    vec_t t;
    n_cmp = 0;
    n_bad = 0;

    // v rs1 rs2 d1 d2 imm pc asel bsel op sub rd we ld
    // exr wrd wwe wd rdy fl | idr v a b rd we op sub ld
    tv[0]  = '{1, 1, 0, 5, 0, 7, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 2, 1, 0,
               0, 0, 0, 0, 1, 0, 1, 1, 5, 7, 2, 1, ALU_ADD, 0, 0};
    tv[1]  = '{1, 6, 7, 1, 2, 0, 0, OPA_RS1, OPB_RS2, ALU_ADD, 0, 3, 1, 0,
               'h99, 0, 0, 0, 1, 0, 1, 1, 1, 2, 3, 1, ALU_ADD, 0, 0};
    tv[2]  = '{1, 3, 3, 'hBAD, 'hBAD, 0, 0, OPA_RS1, OPB_RS2, ALU_ADD, 0, 4, 1, 0,
               'h10, 0, 0, 0, 1, 0, 1, 1, 'h10, 'h10, 4, 1, ALU_ADD, 0, 0};
    tv[3]  = '{1, 4, 4, 'hBAD, 'hBAD, 0, 0, OPA_RS1, OPB_RS2, ALU_ADD, 1, 8, 1, 0,
               'h20, 4, 1, 'h55, 1, 0, 1, 1, 'h20, 'h20, 8, 1, ALU_ADD, 1, 0};
    tv[4]  = '{1, 9, 10, 1, 2, 0, 0, OPA_RS1, OPB_RS2, ALU_XOR, 0, 11, 1, 0,
               'h30, 9, 1, 'h55, 1, 0, 1, 1, 'h55, 2, 11, 1, ALU_XOR, 0, 0};
    tv[5]  = '{1, 1, 0, 'h100, 0, 4, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 5, 1, 1,
               0, 0, 0, 0, 1, 0, 1, 1, 'h100, 4, 5, 1, ALU_ADD, 0, 1};
    tv[6]  = '{1, 5, 0, 'hBAD, 0, 0, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 6, 1, 0,
               'h777, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0};
    tv[7]  = '{1, 5, 0, 'hBAD, 0, 0, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 6, 1, 0,
               'h777, 5, 1, 'hDEAD, 1, 0, 1, 1, 'hDEAD, 0, 6, 1, ALU_ADD, 0, 0};
    tv[8]  = '{1, 1, 0, 3, 0, 1, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 0, 1, 0,
               0, 0, 0, 0, 1, 0, 1, 1, 3, 1, 0, 1, ALU_ADD, 0, 0};
    tv[9]  = '{1, 0, 0, 0, 0, 0, 0, OPA_RS1, OPB_RS2, ALU_ADD, 0, 7, 1, 1,
               'h1234, 0, 1, 'h5678, 1, 0, 1, 1, 0, 0, 7, 1, ALU_ADD, 0, 1};
    tv[10] = '{1, 7, 7, 'hBAD, 'hBAD, 0, 'h400, OPA_PC, OPB_FOUR, ALU_ADD, 0, 13, 1, 0,
               'h99, 0, 0, 0, 1, 0, 1, 1, 'h400, 4, 13, 1, ALU_ADD, 0, 0};
    tv[11] = '{1, 1, 0, 'h11, 0, 'h22, 0, OPA_RS1, OPB_IMM, ALU_OR, 0, 12, 1, 0,
               0, 0, 0, 0, 1, 0, 1, 1, 'h11, 'h22, 12, 1, ALU_OR, 0, 0};
    for (int k = 12; k < 15; k++)
      tv[k] = '{1, 12, 0, 'hBAD, 0, 'h44, 0, OPA_RS1, OPB_IMM, ALU_AND, 0, 14, 1, 0,
                'h99 + k, 0, 0, 0, 0, 0, 0, 1, 'h11, 'h22, 12, 1, ALU_OR, 0, 0};
    tv[15] = '{1, 12, 0, 'hBAD, 0, 'h44, 0, OPA_RS1, OPB_IMM, ALU_AND, 0, 14, 1, 0,
               'h66, 0, 0, 0, 1, 0, 1, 1, 'h66, 'h44, 14, 1, ALU_AND, 0, 0};
    tv[16] = '{1, 1, 0, 'h10, 0, 0, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 15, 1, 1,
               0, 0, 0, 0, 1, 0, 1, 1, 'h10, 0, 15, 1, ALU_ADD, 0, 1};
    tv[17] = '{1, 15, 0, 'h321, 0, 0, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 16, 1, 0,
               0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0};
    tv[18] = '{1, 15, 0, 'h321, 0, 0, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 16, 1, 0,
               0, 0, 0, 0, 1, 0, 1, 1, 'h321, 0, 16, 1, ALU_ADD, 0, 0};
    tv[19] = '{0, 0, 0, 0, 0, 0, 0, OPA_RS1, OPB_RS2, ALU_ADD, 0, 0, 0, 0,
               0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, ALU_ADD, 0, 0};
    tv[20] = '{1, 16, 16, 'hBAD, 'hBAD, 0, 'h400, OPA_ZERO, OPB_FOUR, ALU_SLT, 0, 17, 0, 0,
               'h99, 0, 0, 0, 1, 0, 1, 1, 0, 4, 17, 0, ALU_SLT, 0, 0};
    tv[21] = '{1, 17, 0, 5, 0, 1, 0, OPA_RS1, OPB_IMM, ALU_ADD, 0, 18, 1, 0,
               'hBAD, 0, 0, 0, 1, 0, 1, 1, 5, 1, 18, 1, ALU_ADD, 0, 0};

    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_valid", f_v, 0);
    chk("rst_rd_we", f_we, 0);
    chk("rst_a", f_a, 0);
    chk("rst_b", f_b, 0);
    chk("rst_op", f_op, ALU_ADD);
    chk("rst_ld", f_ld, 0);
    chk("rst_id_ready", f_idr, 1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      chk($sformatf("r%0d_id_ready", i), f_idr, tv[i].e_idr);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_valid", i), f_v, tv[i].e_v);
      chk($sformatf("r%0d_rd_we", i), f_we, tv[i].e_we);
      chk($sformatf("r%0d_is_load", i), f_ld, tv[i].e_ld);
      if (tv[i].e_v) begin
        chk($sformatf("r%0d_a", i), f_a, tv[i].e_a);
        chk($sformatf("r%0d_b", i), f_b, tv[i].e_b);
        chk($sformatf("r%0d_rd", i), f_rd, tv[i].e_rd);
        chk($sformatf("r%0d_op", i), f_op, tv[i].e_op);
        chk($sformatf("r%0d_sub", i), f_sub, tv[i].e_sub);
      end
    end

    // Non-forwarding instance: empty it, then producer/consumer pair
    @(negedge clk);
    idle();
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("nf_flush_valid", n_v, 0);

    @(negedge clk);
    t = tv[1];
    apply(t);
    #1;
    chk("nf_c1_id_ready", n_idr, 1);
    @(posedge clk);
    #1;
    chk("nf_c1_valid", n_v, 1);
    chk("nf_c1_a", n_a, 1);
    chk("nf_c1_b", n_b, 2);

    @(negedge clk);
    t = tv[2];
    apply(t);
    #1;
    chk("nf_c2_id_ready", n_idr, 0);
    @(posedge clk);
    #1;
    chk("nf_c2_bubble", n_v, 0);
    chk("nf_c2_rd_we", n_we, 0);

    @(negedge clk);
    t.wrd = 3;
    t.wwe = 1;
    t.wd  = 'h10;
    apply(t);
    #1;
    chk("nf_c3_id_ready", n_idr, 1);
    @(posedge clk);
    #1;
    chk("nf_c3_valid", n_v, 1);
    chk("nf_c3_a", n_a, 'h10);
    chk("nf_c3_b", n_b, 'h10);
    chk("nf_c3_rd", n_rd, 4);

    // Asynchronous reset between edges, then first accept after release
    t = tv[0];
    t.d1 = 'h42;
    t.imm = 1;
    t.rd = 3;
    @(negedge clk);
    apply(t);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", f_v, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", f_v, 0);
    chk("async_rst_nf_valid", n_v, 0);
    chk("async_rst_a", f_a, 0);
    chk("async_rst_rd_we", f_we, 0);
    @(posedge clk);
    #1;
    chk("in_rst_valid", f_v, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_id_ready", f_idr, 1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", f_v, 1);
    chk("post_rst_a", f_a, 'h42);
    chk("post_rst_b", f_b, 1);
    chk("post_rst_rd", f_rd, 3);

    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("drain_valid", f_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
